// File: rtl/rbd_task_arb_if.sv
// Requester and engine signals of the rbd_task_arb round-robin task sequencer.
// master = arbiter side, slave = requesters plus task engine.
interface rbd_task_arb_if #(
    parameter int P_N_REQ      = 4,
    parameter int P_IDX_WIDTH  = 2,
    parameter int P_DATA_WIDTH = 32
);
    // Handshake: req_run[i] is a one-cycle request, accepted only while req_busy[i]=0;
    // req_data slice i must stay stable while req_busy[i]=1; req_done[i] (with req_err[i]
    // on timeout) closes it. Engine side: task_run launches, task_done completes,
    // task_abort cancels; task_done outside the waiting phase is ignored.
    logic [P_N_REQ-1:0]              req_run;
    logic [P_N_REQ*P_DATA_WIDTH-1:0] req_data;
    logic [P_N_REQ-1:0]              req_busy;
    logic [P_N_REQ-1:0]              req_done;
    logic [P_N_REQ-1:0]              req_err;
    logic                            task_run;
    logic [P_DATA_WIDTH-1:0]         task_data;
    logic [P_IDX_WIDTH-1:0]          task_idx;
    logic                            task_done;
    logic                            task_abort;
    logic [1:0]                      dbg_state;

    modport master (
        input  req_run, req_data, task_done,
        output req_busy, req_done, req_err, task_run, task_data, task_idx, task_abort,
        output dbg_state
    );

    modport slave (
        output req_run, req_data, task_done,
        input  req_busy, req_done, req_err, task_run, task_data, task_idx, task_abort,
        input  dbg_state
    );
endinterface

// File: rtl/rbd_task_arb.sv
// Round-robin arbiter sharing one run/busy/done task engine between P_N_REQ requesters.
// Optional WAIT timeout with abort/error reporting: define RBD_TASK_ARB_TIMEOUT_EN.
module rbd_task_arb #(
    parameter int P_N_REQ      = 4,
    parameter int P_IDX_WIDTH  = 2,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_TMO_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    rbd_task_arb_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    if (P_N_REQ < 2 || (1 << P_IDX_WIDTH) < P_N_REQ) begin : g_bad_idx_width
        $error("rbd_task_arb: P_IDX_WIDTH too small for P_N_REQ");
    end
    if (P_TMO_CYCLES < 2) begin : g_bad_tmo
        $error("rbd_task_arb: P_TMO_CYCLES must be at least 2");
    end

    state_t                  state_q, state_d;
    logic [P_N_REQ-1:0]      pending_q, pending_d;
    logic [P_N_REQ-1:0]      req_busy_q, req_busy_d;
    logic [P_N_REQ-1:0]      req_done_q, req_done_d;
    logic [P_N_REQ-1:0]      req_err_q, req_err_d;
    logic [P_IDX_WIDTH-1:0]  last_grant_q, last_grant_d;
    logic [P_IDX_WIDTH-1:0]  task_idx_q, task_idx_d;
    logic [P_DATA_WIDTH-1:0] task_data_q, task_data_d;
    logic                    task_run_q, task_run_d;
    logic                    task_abort_q, task_abort_d;

    logic [P_DATA_WIDTH-1:0] req_data_arr [P_N_REQ];
    logic                    found;
    logic [P_IDX_WIDTH-1:0]  cand;
    logic [P_IDX_WIDTH-1:0]  pick_idx;

`ifdef RBD_TASK_ARB_TIMEOUT_EN
    localparam int C_TMO_W = (P_TMO_CYCLES > 2) ? $clog2(P_TMO_CYCLES) : 1;
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(P_TMO_CYCLES - 1);
    logic [C_TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    always_comb begin
        for (int i = 0; i < P_N_REQ; i++) begin
            req_data_arr[i] = bus.req_data[i*P_DATA_WIDTH +: P_DATA_WIDTH];
        end
    end

    // First pending requester strictly after last_grant, wrapping around.
    always_comb begin
        found    = 1'b0;
        cand     = '0;
        pick_idx = '0;
        for (int k = 1; k <= P_N_REQ; k++) begin
            cand = P_IDX_WIDTH'((int'(last_grant_q) + k) % P_N_REQ);
            if (!found && pending_q[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | (bus.req_run & ~req_busy_q);
        last_grant_d = last_grant_q;
        task_idx_d   = task_idx_q;
        task_data_d  = task_data_q;
        task_run_d   = 1'b0;
        task_abort_d = 1'b0;
        req_done_d   = '0;
        req_err_d    = '0;
`ifdef RBD_TASK_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    task_idx_d  = pick_idx;
                    task_data_d = req_data_arr[pick_idx];
                    task_run_d  = 1'b1;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                pending_d[task_idx_q] = 1'b0;
                state_d               = S_WAIT;
`ifdef RBD_TASK_ARB_TIMEOUT_EN
                tmo_cnt_d             = '0;
`endif
            end
            S_WAIT: begin
                if (bus.task_done) begin
                    req_done_d[task_idx_q] = 1'b1;
                    state_d                = S_FINISH;
                end
`ifdef RBD_TASK_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == C_TMO_LAST) begin
                    req_done_d[task_idx_q] = 1'b1;
                    req_err_d[task_idx_q]  = 1'b1;
                    task_abort_d           = 1'b1;
                    state_d                = S_FINISH;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            S_FINISH: begin
                last_grant_d = task_idx_q;
                task_data_d  = '0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Busy drops together with req_done: FINISH no longer counts as active.
        req_busy_d = pending_d;
        if (state_d == S_LAUNCH || state_d == S_WAIT) begin
            req_busy_d[task_idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            req_busy_q   <= '0;
            req_done_q   <= '0;
            req_err_q    <= '0;
            last_grant_q <= P_IDX_WIDTH'(P_N_REQ - 1);
            task_idx_q   <= '0;
            task_data_q  <= '0;
            task_run_q   <= 1'b0;
            task_abort_q <= 1'b0;
`ifdef RBD_TASK_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            req_busy_q   <= req_busy_d;
            req_done_q   <= req_done_d;
            req_err_q    <= req_err_d;
            last_grant_q <= last_grant_d;
            task_idx_q   <= task_idx_d;
            task_data_q  <= task_data_d;
            task_run_q   <= task_run_d;
            task_abort_q <= task_abort_d;
`ifdef RBD_TASK_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign bus.req_busy   = req_busy_q;
    assign bus.req_done   = req_done_q;
    assign bus.req_err    = req_err_q;
    assign bus.task_run   = task_run_q;
    assign bus.task_data  = task_data_q;
    assign bus.task_idx   = task_idx_q;
    assign bus.task_abort = task_abort_q;
    assign bus.dbg_state  = state_q;

endmodule
